// File: rtl/jt1943_dwnld_if.sv
// jt1943_dwnld_if
// Groups the download-side byte port (ioctl_*), the SDRAM programming port
// (prog_*), the PROM write strobes and the status flags of jt1943_dwnld.
//   master : the frame/controller side (drives ioctl_*, downloading, prog_rdy)
//   slave  : the downloader itself (drives prog_*, prom_*, ovf, done)
// PROM_NUM sets the width of the one-hot prom_we strobe and must match the
// PROM_NUM of the jt1943_dwnld instance connected to it.
interface jt1943_dwnld_if #(
   parameter int PROM_NUM = 8
);
   logic                downloading;
   logic [21:0]         ioctl_addr;
   logic [7:0]          ioctl_data;
   logic                ioctl_wr;
   logic [21:0]         prog_addr;
   logic [7:0]          prog_data;
   logic [1:0]          prog_mask;
   logic                prog_we;
   logic                prog_rdy;
   logic [PROM_NUM-1:0] prom_we;
   logic [7:0]          prom_addr;
   logic [7:0]          prom_data;
   logic                ovf;
   logic                done;

   modport master (
      output downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
      input  prog_addr, prog_data, prog_mask, prog_we,
      input  prom_we, prom_addr, prom_data, ovf, done
   );

   modport slave (
      input  downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
      output prog_addr, prog_data, prog_mask, prog_we,
      output prom_we, prom_addr, prom_data, ovf, done
   );
endinterface

// File: rtl/jt1943_dwnld.sv
// jt1943_dwnld
// Download-stream writer for the 1943 core. Each ioctl byte is classified by
// address: bytes below PROM_START go through a 2-entry FIFO to the SDRAM
// programming port, bytes in the PROM window become one-cycle one-hot PROM
// write strobes, anything else is discarded and flagged in ovf.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : jt1943_dwnld_if.slave
//            in  downloading, ioctl_addr/data/wr, prog_rdy
//            out prog_addr/data/mask/we, prom_we/addr/data, ovf, done
module jt1943_dwnld #(
   parameter logic [21:0] PROM_START = 22'h5_0000,
   parameter int          PROM_NUM   = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   jt1943_dwnld_if.slave  bus
);

   localparam logic [21:0] PROM_SIZE = 22'(PROM_NUM * 256);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_GAP
   } state_t;

   state_t              state_q, state_d;
   logic [29:0]         mem_q [2];
   logic [29:0]         mem_d [2];
   logic                wr_ptr_q, wr_ptr_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic [1:0]          count_q, count_d;
   logic [21:0]         prog_addr_q, prog_addr_d;
   logic [7:0]          prog_data_q, prog_data_d;
   logic [1:0]          prog_mask_q, prog_mask_d;
   logic                prog_we_q, prog_we_d;
   logic [PROM_NUM-1:0] prom_we_q, prom_we_d;
   logic [7:0]          prom_addr_q, prom_addr_d;
   logic [7:0]          prom_data_q, prom_data_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;
   logic                dl_q, dl_d;
   logic                armed_q, armed_d;

   logic [21:0]         prom_off;
   logic [29:0]         head;
   logic                wr_valid, below_prom, in_prom;
   logic                is_sdram, is_prom, is_oob;
   logic                pop, push_ok, drop;
   logic                dl_rise, dl_fall, drained, fire;

   // Byte classification. Only strobes seen while downloading count; the
   // offset is only meaningful when the address is at or above PROM_START.
   always_comb begin
      prom_off   = bus.ioctl_addr - PROM_START;
      wr_valid   = bus.ioctl_wr & bus.downloading;
      below_prom = bus.ioctl_addr < PROM_START;
      in_prom    = prom_off < PROM_SIZE;
      is_sdram   = wr_valid & below_prom;
      is_prom    = wr_valid & ~below_prom & in_prom;
      is_oob     = wr_valid & ~below_prom & ~in_prom;
   end

   // FIFO bookkeeping. The write engine pops only from IDLE; a pop in the
   // same cycle frees a slot, so a push into a full FIFO is still honoured.
   always_comb begin
      head     = mem_q[rd_ptr_q];
      pop      = (state_q == ST_IDLE) && (count_q != 2'd0);
      push_ok  = is_sdram && ((count_q != 2'd2) || pop);
      drop     = is_sdram && !push_ok;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = {bus.ioctl_addr, bus.ioctl_data};
         wr_ptr_d        = ~wr_ptr_q;
      end
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, push_ok} - {1'b0, pop};
   end

   // SDRAM write engine. prog_* are loaded once from the FIFO head and held
   // unchanged while the request is outstanding; GAP enforces one dead cycle
   // before the next word can be issued.
   always_comb begin
      state_d     = state_q;
      prog_addr_d = prog_addr_q;
      prog_data_d = prog_data_q;
      prog_mask_d = prog_mask_q;
      prog_we_d   = prog_we_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               prog_addr_d = {1'b0, head[29:9]};
               prog_data_d = head[7:0];
               prog_mask_d = head[8] ? 2'b01 : 2'b10;
               prog_we_d   = 1'b1;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.prog_rdy) begin
               prog_we_d   = 1'b0;
               prog_mask_d = 2'b11;
               state_d     = ST_GAP;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // PROM strobes bypass the FIFO and last exactly one cycle; address and
   // data keep their last value so they are valid alongside the strobe.
   always_comb begin
      prom_we_d   = '0;
      prom_addr_d = prom_addr_q;
      prom_data_d = prom_data_q;
      if (is_prom) begin
         for (int i = 0; i < PROM_NUM; i++) begin
            if (prom_off[21:8] == 14'(i)) prom_we_d[i] = 1'b1;
         end
         prom_addr_d = prom_off[7:0];
         prom_data_d = bus.ioctl_data;
      end
   end

   // Status flags. A new loss in the same cycle as the rising edge of
   // downloading wins over the clear. done is armed by a falling edge and
   // fires once the FIFO is empty and the engine is idle.
   always_comb begin
      dl_d    = bus.downloading;
      dl_rise = bus.downloading & ~dl_q;
      dl_fall = ~bus.downloading & dl_q;
      ovf_d   = ovf_q;
      if (dl_rise)       ovf_d = 1'b0;
      if (drop | is_oob) ovf_d = 1'b1;
      drained = (state_q == ST_IDLE) && (count_q == 2'd0);
      fire    = (armed_q | dl_fall) & drained;
      done_d  = fire;
      armed_d = (armed_q | dl_fall) & ~fire;
   end

   // All state registers; reset clears everything, buffered bytes included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         prog_addr_q <= '0;
         prog_data_q <= '0;
         prog_mask_q <= 2'b11;
         prog_we_q   <= 1'b0;
         prom_we_q   <= '0;
         prom_addr_q <= '0;
         prom_data_q <= '0;
         ovf_q       <= 1'b0;
         done_q      <= 1'b0;
         dl_q        <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_q[0]    <= mem_d[0];
         mem_q[1]    <= mem_d[1];
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         prog_addr_q <= prog_addr_d;
         prog_data_q <= prog_data_d;
         prog_mask_q <= prog_mask_d;
         prog_we_q   <= prog_we_d;
         prom_we_q   <= prom_we_d;
         prom_addr_q <= prom_addr_d;
         prom_data_q <= prom_data_d;
         ovf_q       <= ovf_d;
         done_q      <= done_d;
         dl_q        <= dl_d;
         armed_q     <= armed_d;
      end
   end

   assign bus.prog_addr = prog_addr_q;
   assign bus.prog_data = prog_data_q;
   assign bus.prog_mask = prog_mask_q;
   assign bus.prog_we   = prog_we_q;
   assign bus.prom_we   = prom_we_q;
   assign bus.prom_addr = prom_addr_q;
   assign bus.prom_data = prom_data_q;
   assign bus.ovf       = ovf_q;
   assign bus.done      = done_q;

endmodule
